pipe_stall_ctrl: RTL
====================

Name: pipe_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the enable and exception-redirect controls of the IF/ID register, the PC enable, and the bubble/flush controls of ID/EX and EX/MEM. It owns the multiply/divide busy counter and a post-exception drain window. It combines the hazard unit's stall request, HI/LO usage in ID, and M-stage exception/ERET events into one consistent control set per cycle.

Parameters:
MULT_CYC, 5, busy cycles after a mult/multu issue
DIV_CYC, 10, busy cycles after a div/divu issue
DRAIN_CYC, 2, cycles after a redirect during which new exc_req is masked
CNT_W, 4, width of busy and drain counters; must hold max(MULT_CYC, DIV_CYC, DRAIN_CYC)

Ports:
Clk  in  1  pipeline clock, rising edge
Reset  in  1  asynchronous, active-high; clears all state
stall_hazard  in  1  data-hazard stall request from the Tuse/Tnew unit
md_start  in  1  mult/div instruction is in EX this cycle
md_is_div  in  1  qualifies md_start: 1 = div/divu, 0 = mult/multu
md_use_ID  in  1  instruction in ID is mult/div/mfhi/mflo/mthi/mtlo
exc_req  in  1  exception or interrupt taken at the M stage
eret_M  in  1  eret at the M stage
pc_en  out  1  PC register load enable
ifid_en  out  1  IF/ID Enable
ifid_estall  out  1  IF/ID Estall: load EPC/handler PC, insert nop
idex_flush  out  1  ID/EX bubble insert
exmem_flush  out  1  EX/MEM bubble insert
md_busy  out  1  mult/div unit busy
exc_mask  out  1  drain window active; exc_req ignored

Behaviour:
- State: md_cnt[CNT_W], drain_cnt[CNT_W], FSM {RUN, DRAIN}. Reset: md_cnt=0, drain_cnt=0, FSM=RUN.
- Outputs are combinational from state and inputs. While Reset=1 they are forced to: pc_en=1, ifid_en=1, ifid_estall=0, idex_flush=0, exmem_flush=0, md_busy=0, exc_mask=0.
- md_busy = (md_cnt != 0).
- md_start with md_cnt==0 loads DIV_CYC if md_is_div, otherwise MULT_CYC, at the next edge. md_busy rises in the cycle after md_start.
- With md_cnt != 0, md_cnt decrements by 1 every edge and saturates at 0. md_start while busy is ignored; the hazard logic prevents it.
- Effective event: take = (exc_req & FSM==RUN) | eret_M. ERET is never masked.
- Priority each cycle: take > stall > normal.
- take=1:
  - ifid_estall=1, idex_flush=1, exmem_flush=1, pc_en=1, ifid_en=1 (don't-care for IF/ID, since Estall dominates).
  - Next edge: md_cnt cleared to 0, FSM goes to DRAIN, drain_cnt loaded with DRAIN_CYC.
  - stall_hazard and md_use_ID are ignored in this cycle.
- stall = stall_hazard | (md_busy & md_use_ID). When stall=1 and take=0: pc_en=0, ifid_en=0, idex_flush=1, exmem_flush=0, ifid_estall=0.
- Normal (no take, no stall): pc_en=1, ifid_en=1, all flushes 0.
- DRAIN:
  - exc_mask=1; drain_cnt decrements each edge.
  - When drain_cnt==1 at an edge, FSM returns to RUN, so exc_mask lasts exactly DRAIN_CYC cycles.
  - Stalls and md counting behave normally inside DRAIN.
  - eret_M in DRAIN reloads drain_cnt with DRAIN_CYC.
- Reset mid-operation (busy or drain) clears all state immediately. No partial counts survive.

Test Plan:
- Reset asserted mid-DIV (md_cnt=7) and during DRAIN -> outputs take reset values immediately, without waiting for a clock edge; after release md_busy=0 and exc_mask=0.
- md_start=1, md_is_div=0 at cycle 0, md_use_ID=0 -> md_busy=1 in cycles 1..5 and 0 at cycle 6; pc_en and ifid_en stay 1 throughout.
- md_start with md_is_div=1 at cycle 0, md_use_ID=1 from cycle 1 -> pc_en=0, ifid_en=0, idex_flush=1 in cycles 1..10; normal flow at cycle 11.
- stall_hazard=1 and exc_req=1 in the same cycle -> ifid_estall=1, idex_flush=1, exmem_flush=1, pc_en=1; next cycle exc_mask=1.
- exc_req=1 at cycle 0, then exc_req=1 again at cycles 1 and 2 -> only cycle 0 redirects; exc_mask=1 in cycles 1..2; exc_req at cycle 3 redirects again.
- exc_req during DIV busy (md_cnt=6) -> next cycle md_busy=0, and md_use_ID no longer stalls.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : pipe_stall_ctrl
// Description : Stall/flush sequencer for the 5-stage pipeline; owns the
//               mult/div busy counter and the post-redirect drain window.
// Revision    : 1.0 - initial release
//==============================================================================
module pipe_stall_ctrl #(
    parameter int MULT_CYC  = 5,
    parameter int DIV_CYC   = 10,
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic stall_hazard,
    input  logic md_start,
    input  logic md_is_div,
    input  logic md_use_ID,
    input  logic exc_req,
    input  logic eret_M,
    output logic pc_en,
    output logic ifid_en,
    output logic ifid_estall,
    output logic idex_flush,
    output logic exmem_flush,
    output logic md_busy,
    output logic exc_mask
);

    localparam logic [0:0]       c_st_run     = 1'b0;
    localparam logic [0:0]       c_st_drain   = 1'b1;
    localparam logic [CNT_W-1:0] c_mult_load  = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] c_div_load   = CNT_W'(DIV_CYC);
    localparam logic [CNT_W-1:0] c_drain_load = CNT_W'(DRAIN_CYC);
    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_md_cnt;
    logic [CNT_W-1:0] r_drain_cnt;

    logic w_busy;
    logic w_in_drain;
    logic w_take;
    logic w_stall;

    assign w_busy     = (r_md_cnt != '0);
    assign w_in_drain = (r_state == c_st_drain);
    // ERET always redirects; only exceptions are masked while draining.
    assign w_take     = (exc_req & ~w_in_drain) | eret_M;
    assign w_stall    = stall_hazard | (w_busy & md_use_ID);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_estall = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        md_busy     = 1'b0;
        exc_mask    = 1'b0;
        if (!Reset) begin
            md_busy  = w_busy;
            exc_mask = w_in_drain;
            if (w_take) begin
                ifid_estall = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (w_stall) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= c_st_run;
            r_md_cnt    <= '0;
            r_drain_cnt <= '0;
        end else if (w_take) begin
            // Redirect squashes any in-flight mult/div and (re)opens the drain window.
            r_state     <= c_st_drain;
            r_md_cnt    <= '0;
            r_drain_cnt <= c_drain_load;
        end else begin
            if (w_busy) begin
                r_md_cnt <= r_md_cnt - c_one;
            end else if (md_start) begin
                r_md_cnt <= md_is_div ? c_div_load : c_mult_load;
            end
            if (w_in_drain) begin
                if (r_drain_cnt == c_one) begin
                    r_state     <= c_st_run;
                    r_drain_cnt <= '0;
                end else begin
                    r_drain_cnt <= r_drain_cnt - c_one;
                end
            end
        end
    end

endmodule
`default_nettype wire
